reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised power-on and reset sequencer for the camera/DDR/VGA designs. It holds the PLL in reset for a settle period, then waits for a stable lock. Once locked, it releases N_CH downstream reset domains one at a time, with a fixed gap between each. It also re-runs the sequence when PLL lock is lost or when a soft reset is requested. It sits between the board reset/PLL and every module that needs an ordered reset release, for example the sensor config, then the DDR controller, then the frame buffer, then the VGA timing.

## Interface
- DELAY_CNT, 1_000_000: settle cycles with pll_areset held high after reset.
- N_CH, 4: number of reset channels, 1..16.
- STAGE_GAP, 16: cycles between successive channel releases, ≥1.
- LOCK_STABLE, 64: consecutive cycles the synchronised lock must be high before release, ≥1.
- LOCK_TIMEOUT, 65535: cycles in WAIT_LOCK before the PLL is reset again.
- PLL_RST_CYCLES, 8: pll_areset pulse length on a retry.
- CNT_W, 24: shared counter width. Every count parameter must be < 2^CNT_W; elaboration fails otherwise.
- clk, in, 1: reference clock (50 MHz).
- rst, in, 1: synchronous, active-high reset.
- pll_locked, in, 1: PLL lock, asynchronous; synchronised internally through 2 flops (lock_s).
- soft_rst, in, 1: single-cycle request to re-release all channels without resetting the PLL.
- pll_areset, out, 1: active-high PLL reset.
- ch_rst_n, out, N_CH: active-low channel resets, registered. Consumers re-synchronise them into their own clock domains.
- all_ready, out, 1: high while every channel is released.
- state, out, 3: SETTLE=0, WAIT_LOCK=1, PLL_RST=2, RELEASE=3, RUN=4.
- retry_cnt, out, 8: count of PLL retries plus lock losses; saturates at 255.

## Operation
- Reset (rst=1): state=SETTLE, counters=0, pll_areset=1, ch_rst_n=0, all_ready=0, retry_cnt=0, lock synchroniser=0.
- SETTLE
  - pll_areset=1 for DELAY_CNT cycles, then go to WAIT_LOCK with pll_areset=0.
- WAIT_LOCK
  - Stable counter increments while lock_s=1 and clears when lock_s=0.
  - When it reaches LOCK_STABLE, go to RELEASE.
  - If LOCK_TIMEOUT cycles elapse first, go to PLL_RST and increment retry_cnt.
  - Stable-counter completion wins if both happen in the same cycle.
- PLL_RST
  - pll_areset=1 and ch_rst_n=0 for PLL_RST_CYCLES, then go to WAIT_LOCK with counters cleared.
- RELEASE
  - Gap counter runs from entry.
  - ch_rst_n[k] rises STAGE_GAP·(k+1) cycles after entry and stays high; bits rise in index order.
  - The cycle bit N_CH-1 rises, state becomes RUN and all_ready=1.
- RUN
  - Outputs hold.
- Lock loss
  - Applies in RELEASE or RUN when lock_s=0.
  - Next cycle: ch_rst_n=0, all_ready=0, state=PLL_RST, retry_cnt increments.
- Soft reset
  - Applies to soft_rst=1 in RELEASE or RUN with lock_s=1.
  - Next cycle: ch_rst_n=0, all_ready=0, state re-enters RELEASE with the gap counter at 0. retry_cnt is unchanged and pll_areset stays 0.
  - soft_rst is ignored in SETTLE, WAIT_LOCK and PLL_RST.
- Priority: rst > lock loss > soft_rst > normal progression.
- Invariants:
  - ch_rst_n is never nonzero outside RELEASE and RUN.
  - pll_areset is never 1 while any ch_rst_n bit is 1.

## Timing
- Cycle 0 is the first edge with rst=0.
- State is SETTLE for cycles 0..DELAY_CNT-1 and WAIT_LOCK from cycle DELAY_CNT.
- Lock input to lock_s latency: 2 cycles.
- WAIT_LOCK to RELEASE takes exactly LOCK_STABLE cycles when lock_s is already high.
- Release window:
  - Channel k releases at entry + STAGE_GAP·(k+1).
  - all_ready rises in the same cycle as the last channel.
- Lock drop to channel-reset assertion: 2 cycles of synchronisation + 1 registered cycle = 3 cycles.
- soft_rst to ch_rst_n=0: 1 cycle.
- A soft_rst arriving mid-RELEASE restarts the release order from channel 0.
- A mid-sequence rst returns all outputs to their reset values on the next edge.
- retry_cnt holds at 255 without wrapping.

## Test plan
Bench parameters: DELAY_CNT=100, N_CH=4, STAGE_GAP=8, LOCK_STABLE=4, LOCK_TIMEOUT=50, PLL_RST_CYCLES=8.

- Nominal power-up, pll_locked=1 throughout:
  - pll_areset falls at cycle 100.
  - RELEASE at cycle 104.
  - ch_rst_n = 0001@112, 0011@120, 0111@128, 1111@136.
  - all_ready=1 at 136.
- Lock never asserts:
  - Enters PLL_RST at cycle 150; pll_areset high for 150..157.
  - WAIT_LOCK again at 158; retry_cnt=1; next retry at 208.
- Lock drop in RUN at cycle 200:
  - ch_rst_n=0 and all_ready=0 at cycle 203; state=PLL_RST.
  - Re-lock then gives the full staged release again.
- soft_rst pulse at cycle 124, during RELEASE:
  - ch_rst_n=0 at 125.
  - Channel 0 at 133, channel 3 at 157.
  - pll_areset stays 0; retry_cnt unchanged.
- rst asserted at cycle 130 with soft_rst and a lock drop in the same cycle: all outputs at reset values at 131 and SETTLE restarts.
- Force 300 timeouts: retry_cnt saturates at 255.

Source files
------------

// File: rtl/reset_sequencer.sv
// Ordered reset release: PLL settle, lock qualification, then staged channel releases with retry/soft-reset handling.
// Latency: lock change seen 2 cycles after pll_locked, outputs registered one cycle later; no backpressure (free-running).
module reset_sequencer #(
    parameter int unsigned DELAY_CNT      = 1_000_000,
    parameter int unsigned N_CH           = 4,
    parameter int unsigned STAGE_GAP      = 16,
    parameter int unsigned LOCK_STABLE    = 64,
    parameter int unsigned LOCK_TIMEOUT   = 65535,
    parameter int unsigned PLL_RST_CYCLES = 8,
    parameter int unsigned CNT_W          = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pll_locked,
    input  logic            soft_rst,
    output logic            pll_areset,
    output logic [N_CH-1:0] ch_rst_n,
    output logic            all_ready,
    output logic [2:0]      state,
    output logic [7:0]      retry_cnt
);

    localparam longint unsigned CNT_LIM = 64'd1 << CNT_W;

    if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
        $error("reset_sequencer: N_CH must be 1..16");
    end
    if (STAGE_GAP < 1 || LOCK_STABLE < 1 || LOCK_TIMEOUT < 1 || PLL_RST_CYCLES < 1) begin : g_bad_min
        $error("reset_sequencer: gap, stable, timeout and pll reset counts must be >= 1");
    end
    if (longint'(DELAY_CNT) >= CNT_LIM || longint'(LOCK_STABLE) >= CNT_LIM ||
        longint'(LOCK_TIMEOUT) >= CNT_LIM || longint'(PLL_RST_CYCLES) >= CNT_LIM ||
        longint'(STAGE_GAP) * longint'(N_CH) >= CNT_LIM) begin : g_bad_width
        $error("reset_sequencer: a count parameter does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] DELAY_C   = CNT_W'(DELAY_CNT);
    localparam logic [CNT_W-1:0] STABLE_C  = CNT_W'(LOCK_STABLE);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] PLLRST_C  = CNT_W'(PLL_RST_CYCLES);
    localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(STAGE_GAP * N_CH);

    typedef enum logic [2:0] {
        SETTLE    = 3'd0,
        WAIT_LOCK = 3'd1,
        PLL_RST   = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] stable;
    logic             lock_meta;
    logic             lock_s;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] stable_nx;

    assign cnt_nx    = cnt + 1'b1;
    assign stable_nx = stable + 1'b1;
    assign state     = st;

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= SETTLE;
            cnt        <= '0;
            stable     <= '0;
            pll_areset <= 1'b1;
            ch_rst_n   <= '0;
            all_ready  <= 1'b0;
            retry_cnt  <= '0;
            lock_meta  <= 1'b0;
            lock_s     <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
            case (st)
                SETTLE: begin
                    if (cnt == DELAY_C) begin
                        st         <= WAIT_LOCK;
                        cnt        <= '0;
                        stable     <= '0;
                        pll_areset <= 1'b0;
                    end else begin
                        cnt <= cnt_nx;
                    end
                end
                WAIT_LOCK: begin
                    // a lock that qualifies on the timeout cycle still counts as good
                    if (lock_s && stable_nx == STABLE_C) begin
                        st  <= RELEASE;
                        cnt <= '0;
                    end else if (cnt_nx == TIMEOUT_C) begin
                        st         <= PLL_RST;
                        cnt        <= '0;
                        pll_areset <= 1'b1;
                        if (retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
                    end else begin
                        cnt <= cnt_nx;
                    end
                    stable <= lock_s ? stable_nx : '0;
                end
                PLL_RST: begin
                    if (cnt_nx == PLLRST_C) begin
                        st         <= WAIT_LOCK;
                        cnt        <= '0;
                        stable     <= '0;
                        pll_areset <= 1'b0;
                    end else begin
                        cnt <= cnt_nx;
                    end
                end
                RELEASE, RUN: begin
                    if (!lock_s) begin
                        st         <= PLL_RST;
                        cnt        <= '0;
                        pll_areset <= 1'b1;
                        ch_rst_n   <= '0;
                        all_ready  <= 1'b0;
                        if (retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
                    end else if (soft_rst) begin
                        st        <= RELEASE;
                        cnt       <= '0;
                        ch_rst_n  <= '0;
                        all_ready <= 1'b0;
                    end else if (st == RELEASE) begin
                        cnt <= cnt_nx;
                        for (int k = 0; k < int'(N_CH); k++) begin
                            if (cnt_nx == CNT_W'(STAGE_GAP * (k + 1))) ch_rst_n[k] <= 1'b1;
                        end
                        if (cnt_nx == LAST_C) begin
                            st        <= RUN;
                            all_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    st         <= SETTLE;
                    cnt        <= '0;
                    stable     <= '0;
                    pll_areset <= 1'b1;
                    ch_rst_n   <= '0;
                    all_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: directed scenarios push expected snapshots keyed by cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       soft_rst = 1'b0;
    logic       pll_areset;
    logic [3:0] ch_rst_n;
    logic       all_ready;
    logic [2:0] state;
    logic [7:0] retry_cnt;

    reset_sequencer #(
        .DELAY_CNT(100), .N_CH(4), .STAGE_GAP(8), .LOCK_STABLE(4),
        .LOCK_TIMEOUT(50), .PLL_RST_CYCLES(8), .CNT_W(24)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked), .soft_rst(soft_rst),
        .pll_areset(pll_areset), .ch_rst_n(ch_rst_n), .all_ready(all_ready),
        .state(state), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tk;
        string      nm;
        logic [2:0] st;
        logic       pa;
        logic [3:0] ch;
        logic       ar;
        logic [7:0] rc;
    } exp_t;

    exp_t sb[$];
    int   tick = 0;
    int   base = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) tick <= tick + 1;

    // monitor: invariants every cycle, scoreboard entries on their cycle
    always @(negedge clk) begin
        exp_t e;
        n_cmp++;
        if ((pll_areset && ch_rst_n != 4'b0) || (ch_rst_n != 4'b0 && state != 3'd3 && state != 3'd4)) begin
            n_bad++;
            $display("FAIL invariant tick=%0d got st=%0d pa=%0b ch=%b, want ch=0 outside RELEASE/RUN and no pa with ch",
                     tick, state, pll_areset, ch_rst_n);
        end
        while (sb.size() > 0 && sb[0].tk <= tick) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.tk != tick ||
                {state, pll_areset, ch_rst_n, all_ready, retry_cnt} !== {e.st, e.pa, e.ch, e.ar, e.rc}) begin
                n_bad++;
                $display("FAIL %s tick=%0d(want %0d) got st=%0d pa=%0b ch=%b ar=%0b rc=%0d want st=%0d pa=%0b ch=%b ar=%0b rc=%0d",
                         e.nm, tick, e.tk, state, pll_areset, ch_rst_n, all_ready, retry_cnt,
                         e.st, e.pa, e.ch, e.ar, e.rc);
            end
        end
    end

    task automatic ex(input int c, input string nm, input logic [2:0] st, input logic pa,
                      input logic [3:0] ch, input logic ar, input int rc);
        exp_t e;
        e.tk = base + c; e.nm = nm; e.st = st; e.pa = pa; e.ch = ch; e.ar = ar; e.rc = 8'(rc);
        sb.push_back(e);
    endtask

    // returns just after active edge c of the current scenario
    task automatic wait_cyc(input int c);
        while (tick < base + c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic lock);
        exp_t e;
        rst = 1'b1;
        soft_rst = 1'b0;
        pll_locked = lock;
        repeat (3) @(posedge clk);
        #1;
        e.tk = tick; e.nm = "reset_state"; e.st = 3'd0; e.pa = 1'b1; e.ch = 4'b0; e.ar = 1'b0; e.rc = 8'd0;
        sb.push_back(e);
        rst = 1'b0;
        base = tick + 1;
    endtask

    initial begin
        // nominal power-up, then lock drop in RUN and re-lock
        do_reset(1'b1);
        ex(0,   "settle_c0",      0, 1, 4'b0000, 0, 0);
        ex(99,  "settle_end",     0, 1, 4'b0000, 0, 0);
        ex(100, "wait_lock",      1, 0, 4'b0000, 0, 0);
        ex(103, "wait_stable",    1, 0, 4'b0000, 0, 0);
        ex(104, "release_entry",  3, 0, 4'b0000, 0, 0);
        ex(111, "pre_ch0",        3, 0, 4'b0000, 0, 0);
        ex(112, "ch0",            3, 0, 4'b0001, 0, 0);
        ex(120, "ch1",            3, 0, 4'b0011, 0, 0);
        ex(128, "ch2",            3, 0, 4'b0111, 0, 0);
        ex(135, "pre_ch3",        3, 0, 4'b0111, 0, 0);
        ex(136, "ch3_run",        4, 0, 4'b1111, 1, 0);
        ex(200, "run_hold",       4, 0, 4'b1111, 1, 0);
        ex(202, "drop_sync",      4, 0, 4'b1111, 1, 0);
        ex(203, "drop_pllrst",    2, 1, 4'b0000, 0, 1);
        ex(210, "drop_pllrst_end",2, 1, 4'b0000, 0, 1);
        ex(211, "relock_wait",    1, 0, 4'b0000, 0, 1);
        ex(215, "relock_release", 3, 0, 4'b0000, 0, 1);
        ex(223, "relock_ch0",     3, 0, 4'b0001, 0, 1);
        ex(246, "relock_ch2",     3, 0, 4'b0111, 0, 1);
        ex(247, "relock_run",     4, 0, 4'b1111, 1, 1);
        wait_cyc(200);
        pll_locked = 1'b0;
        wait_cyc(203);
        pll_locked = 1'b1;
        wait_cyc(250);

        // rst mid-release together with soft_rst and lock drop
        do_reset(1'b1);
        ex(130, "pre_rst",        3, 0, 4'b0111, 0, 0);
        ex(131, "rst_mid",        0, 1, 4'b0000, 0, 0);
        wait_cyc(130);
        rst = 1'b1; soft_rst = 1'b1; pll_locked = 1'b0;
        wait_cyc(131);
        rst = 1'b0; soft_rst = 1'b0; pll_locked = 1'b1;
        base = tick + 1;

        // soft_rst in SETTLE (ignored), mid-RELEASE and in RUN
        ex(0,   "restart_c0",     0, 1, 4'b0000, 0, 0);
        ex(51,  "soft_settle",    0, 1, 4'b0000, 0, 0);
        ex(100, "restart_wait",   1, 0, 4'b0000, 0, 0);
        ex(120, "soft_pre",       3, 0, 4'b0011, 0, 0);
        ex(124, "soft_at",        3, 0, 4'b0011, 0, 0);
        ex(125, "soft_clear",     3, 0, 4'b0000, 0, 0);
        ex(132, "soft_pre_ch0",   3, 0, 4'b0000, 0, 0);
        ex(133, "soft_ch0",       3, 0, 4'b0001, 0, 0);
        ex(141, "soft_ch1",       3, 0, 4'b0011, 0, 0);
        ex(149, "soft_ch2",       3, 0, 4'b0111, 0, 0);
        ex(156, "soft_pre_ch3",   3, 0, 4'b0111, 0, 0);
        ex(157, "soft_ch3",       4, 0, 4'b1111, 1, 0);
        ex(170, "run_soft_at",    4, 0, 4'b1111, 1, 0);
        ex(171, "run_soft_clear", 3, 0, 4'b0000, 0, 0);
        ex(178, "run_soft_pre",   3, 0, 4'b0000, 0, 0);
        ex(179, "run_soft_ch0",   3, 0, 4'b0001, 0, 0);
        wait_cyc(50);  soft_rst = 1'b1;
        wait_cyc(51);  soft_rst = 1'b0;
        wait_cyc(124); soft_rst = 1'b1;
        wait_cyc(125); soft_rst = 1'b0;
        wait_cyc(170); soft_rst = 1'b1;
        wait_cyc(171); soft_rst = 1'b0;
        wait_cyc(185);

        // stable completion lands on the timeout cycle
        do_reset(1'b0);
        ex(100, "tie_wait",       1, 0, 4'b0000, 0, 0);
        ex(149, "tie_pre",        1, 0, 4'b0000, 0, 0);
        ex(150, "tie_release",    3, 0, 4'b0000, 0, 0);
        ex(158, "tie_ch0",        3, 0, 4'b0001, 0, 0);
        ex(182, "tie_run",        4, 0, 4'b1111, 1, 0);
        wait_cyc(144);
        pll_locked = 1'b1;
        wait_cyc(185);

        // lock never asserts: retries and saturation
        do_reset(1'b0);
        ex(100,   "to_wait",      1, 0, 4'b0000, 0, 0);
        ex(149,   "to_pre",       1, 0, 4'b0000, 0, 0);
        ex(150,   "to_retry1",    2, 1, 4'b0000, 0, 1);
        ex(157,   "to_pllrst_end",2, 1, 4'b0000, 0, 1);
        ex(158,   "to_rewait",    1, 0, 4'b0000, 0, 1);
        ex(161,   "soft_in_wait", 1, 0, 4'b0000, 0, 1);
        ex(207,   "to_pre2",      1, 0, 4'b0000, 0, 1);
        ex(208,   "to_retry2",    2, 1, 4'b0000, 0, 2);
        ex(14824, "to_retry254",  2, 1, 4'b0000, 0, 254);
        ex(14881, "to_pre255",    1, 0, 4'b0000, 0, 254);
        ex(14882, "to_retry255",  2, 1, 4'b0000, 0, 255);
        ex(14940, "to_sat256",    2, 1, 4'b0000, 0, 255);
        ex(17492, "to_sat300",    2, 1, 4'b0000, 0, 255);
        wait_cyc(160); soft_rst = 1'b1;
        wait_cyc(161); soft_rst = 1'b0;
        wait_cyc(17500);

        repeat (4) @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s never checked: want tick=%0d, run ended at tick=%0d", e.nm, e.tk, tick);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
